// File: rtl/vdp_super_palette_lookup.sv
// Palette lookup for the super-res pixel path: 256x9 palette RAM, V9958-style CPU write port,
// MSX2 default-palette initialiser and a fixed 2-cycle address-to-RGB pipeline.
module vdp_super_palette_lookup (
    input  logic       reset,
    input  logic       clk,
    input  logic       pal_ptr_wr,
    input  logic [7:0] pal_ptr_data,
    input  logic       pal_data_wr,
    input  logic [7:0] pal_data,
    input  logic [7:0] palette_addr,
    input  logic       blank,
    output logic       init_busy,
    output logic [7:0] video_red,
    output logic [7:0] video_green,
    output logic [7:0] video_blue,
    output logic       blank_out
);

    // Handshake: none. pal_ptr_wr / pal_data_wr are single-cycle strobes that the CPU side only
    // issues while init_busy is low; strobes seen while init_busy is high are dropped. The pixel
    // path accepts one address every clk and never stalls.

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_init_cnt;

    logic [7:0] r_ptr;
    logic       r_phase;
    logic [2:0] r_lat_r;
    logic [2:0] r_lat_b;

    logic       w_cpu_en;
    logic       w_ptr_load;
    logic       w_data_strobe;
    logic       w_commit;
    logic       w_we;
    logic [7:0] w_waddr;
    logic [8:0] w_wdata;
    logic       w_unused;

    logic [8:0] r_palette [0:255];
    logic [8:0] r_rd_data;
    logic       r_blank_s1;
    logic       r_busy_s1;

    function automatic logic [8:0] default_entry(input logic [7:0] idx);
        logic [8:0] v;
        case (idx)
            8'd2:    v = {3'd1, 3'd6, 3'd1};
            8'd3:    v = {3'd3, 3'd7, 3'd3};
            8'd4:    v = {3'd1, 3'd1, 3'd7};
            8'd5:    v = {3'd2, 3'd3, 3'd7};
            8'd6:    v = {3'd5, 3'd1, 3'd1};
            8'd7:    v = {3'd2, 3'd6, 3'd7};
            8'd8:    v = {3'd7, 3'd1, 3'd1};
            8'd9:    v = {3'd7, 3'd3, 3'd3};
            8'd10:   v = {3'd6, 3'd6, 3'd1};
            8'd11:   v = {3'd6, 3'd6, 3'd4};
            8'd12:   v = {3'd1, 3'd4, 3'd1};
            8'd13:   v = {3'd6, 3'd2, 3'd5};
            8'd14:   v = {3'd5, 3'd5, 3'd5};
            8'd15:   v = {3'd7, 3'd7, 3'd7};
            default: v = 9'd0;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] expand3(input logic [2:0] v);
        return {v, v, v[2:1]};
    endfunction

    // Initialiser FSM: state register, next-state logic, outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_INIT;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_INIT && r_init_cnt == 8'hFF) w_state_next = ST_RUN;
    end

    always_comb begin
        init_busy = (r_state == ST_INIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          r_init_cnt <= 8'd0;
        else if (init_busy) r_init_cnt <= r_init_cnt + 8'd1;
    end

    // A pointer strobe beats a simultaneous data strobe and discards any half-written entry.
    assign w_cpu_en      = ~init_busy;
    assign w_ptr_load    = w_cpu_en & pal_ptr_wr;
    assign w_data_strobe = w_cpu_en & pal_data_wr & ~pal_ptr_wr;
    assign w_commit      = w_data_strobe & r_phase;
    assign w_unused      = ^{pal_data[7], pal_data[3]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr   <= 8'd0;
            r_phase <= 1'b0;
            r_lat_r <= 3'd0;
            r_lat_b <= 3'd0;
        end else if (w_ptr_load) begin
            r_ptr   <= pal_ptr_data;
            r_phase <= 1'b0;
        end else if (w_data_strobe) begin
            if (!r_phase) begin
                r_lat_r <= pal_data[6:4];
                r_lat_b <= pal_data[2:0];
                r_phase <= 1'b1;
            end else begin
                r_ptr   <= r_ptr + 8'd1;
                r_phase <= 1'b0;
            end
        end
    end

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_ptr;
        w_wdata = {r_lat_r, pal_data[2:0], r_lat_b};
        if (init_busy) begin
            w_we    = 1'b1;
            w_waddr = r_init_cnt;
            w_wdata = default_entry(r_init_cnt);
        end else if (w_commit) begin
            w_we = 1'b1;
        end
    end

    // RAM is not reset; the initialiser rewrites every entry after each reset.
    always_ff @(posedge clk) begin
        if (w_we) r_palette[w_waddr] <= w_wdata;
    end

    // Read-before-write: a same-cycle commit to the read address returns the old entry.
    always_ff @(posedge clk) begin
        r_rd_data <= r_palette[palette_addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blank_s1 <= 1'b0;
            r_busy_s1  <= 1'b1;
        end else begin
            r_blank_s1 <= blank;
            r_busy_s1  <= init_busy;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            video_red   <= 8'd0;
            video_green <= 8'd0;
            video_blue  <= 8'd0;
            blank_out   <= 1'b0;
        end else begin
            blank_out <= r_blank_s1;
            if (r_blank_s1 || r_busy_s1) begin
                video_red   <= 8'd0;
                video_green <= 8'd0;
                video_blue  <= 8'd0;
            end else begin
                video_red   <= expand3(r_rd_data[8:6]);
                video_green <= expand3(r_rd_data[5:3]);
                video_blue  <= expand3(r_rd_data[2:0]);
            end
        end
    end

endmodule

// File: tb/tb_vdp_super_palette_lookup.sv
// Scoreboard bench for vdp_super_palette_lookup: one pixel pushed per clk, monitor compares
// {blank_out, R, G, B} two clks later against hand-computed expectations.
module tb_vdp_super_palette_lookup;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pal_ptr_wr = 1'b0;
    logic [7:0] pal_ptr_data = 8'd0;
    logic       pal_data_wr = 1'b0;
    logic [7:0] pal_data = 8'd0;
    logic [7:0] palette_addr = 8'd0;
    logic       blank = 1'b0;
    logic       init_busy;
    logic [7:0] video_red;
    logic [7:0] video_green;
    logic [7:0] video_blue;
    logic       blank_out;

    int checks = 0;
    int failures = 0;
    int pix_id = 0;

    logic [24:0] exp_q[$];
    bit          chk_q[$];
    int          id_q[$];

    vdp_super_palette_lookup dut (
        .reset        (reset),
        .clk          (clk),
        .pal_ptr_wr   (pal_ptr_wr),
        .pal_ptr_data (pal_ptr_data),
        .pal_data_wr  (pal_data_wr),
        .pal_data     (pal_data),
        .palette_addr (palette_addr),
        .blank        (blank),
        .init_busy    (init_busy),
        .video_red    (video_red),
        .video_green  (video_green),
        .video_blue   (video_blue),
        .blank_out    (blank_out)
    );

    always #5 clk = ~clk;

    // One pixel per call: drive inputs at the falling edge, record the expectation, wait a clk.
    task automatic cyc(input logic [7:0] a, input logic b, input bit c, input logic [24:0] e);
        palette_addr = a;
        blank        = b;
        exp_q.push_back(e);
        chk_q.push_back(c);
        id_q.push_back(pix_id);
        pix_id++;
        @(negedge clk);
    endtask

    task automatic ptr_wr(input logic [7:0] v);
        pal_ptr_wr   = 1'b1;
        pal_ptr_data = v;
        cyc(8'd0, 1'b0, 1'b0, 25'd0);
        pal_ptr_wr   = 1'b0;
    endtask

    task automatic dat_wr(input logic [7:0] v, input logic [7:0] a, input bit c, input logic [24:0] e);
        pal_data_wr = 1'b1;
        pal_data    = v;
        cyc(a, 1'b0, c, e);
        pal_data_wr = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Busy must last exactly 256 clks; CPU strobes during that window must be ignored.
    task automatic run_init();
        chk("busy_at_release", {31'd0, init_busy}, 32'd1);
        for (int i = 0; i < 256; i++) begin
            if (i == 10) begin
                pal_ptr_wr   = 1'b1;
                pal_ptr_data = 8'h40;
            end
            if (i == 12 || i == 13) begin
                pal_data_wr = 1'b1;
                pal_data    = 8'h77;
            end
            cyc(8'd15, 1'b0, 1'b1, 25'd0);
            pal_ptr_wr  = 1'b0;
            pal_data_wr = 1'b0;
            if (i == 254) chk("busy_255_clks", {31'd0, init_busy}, 32'd1);
        end
        chk("busy_dropped", {31'd0, init_busy}, 32'd0);
    endtask

    initial begin : monitor
        logic [24:0] e;
        logic [24:0] got;
        bit          c;
        int          id;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() >= 3) begin
                e  = exp_q.pop_front();
                c  = chk_q.pop_front();
                id = id_q.pop_front();
                if (c) begin
                    got = {blank_out, video_red, video_green, video_blue};
                    checks++;
                    if (got !== e) begin
                        failures++;
                        $display("FAIL pixel%0d got=%h exp=%h", id, got, e);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        blank = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, init_busy}, 32'd1);
        chk("reset_outputs", {7'd0, blank_out, video_red, video_green, video_blue}, 32'd0);
        reset = 1'b0;
        run_init();

        // Default palette.
        cyc(8'd15,  1'b0, 1'b1, 25'h0FFFFFF);
        cyc(8'd2,   1'b0, 1'b1, 25'h024DB24);
        cyc(8'd200, 1'b0, 1'b1, 25'h0000000);
        cyc(8'd5,   1'b0, 1'b1, 25'h0496DFF);

        // Pointer is 0 after init; strobes during init were dropped.
        dat_wr(8'h11, 8'd0, 1'b0, 25'd0);
        dat_wr(8'h01, 8'd0, 1'b0, 25'd0);
        cyc(8'h00, 1'b0, 1'b1, 25'h0242424);

        ptr_wr(8'h20);
        dat_wr(8'h52, 8'd0, 1'b0, 25'd0);
        dat_wr(8'h03, 8'd0, 1'b0, 25'd0);
        cyc(8'h20, 1'b0, 1'b1, 25'h0B66D49);
        dat_wr(8'h11, 8'd0, 1'b0, 25'd0);
        dat_wr(8'h02, 8'd0, 1'b0, 25'd0);
        cyc(8'h21, 1'b0, 1'b1, 25'h0244924);

        // Pointer wrap.
        ptr_wr(8'hFF);
        dat_wr(8'h70, 8'd0, 1'b0, 25'd0);
        dat_wr(8'h00, 8'd0, 1'b0, 25'd0);
        dat_wr(8'h07, 8'd0, 1'b0, 25'd0);
        dat_wr(8'h07, 8'd0, 1'b0, 25'd0);
        cyc(8'hFF, 1'b0, 1'b1, 25'h0FF0000);
        cyc(8'h00, 1'b0, 1'b1, 25'h000FFFF);
        dat_wr(8'h40, 8'd0, 1'b0, 25'd0);
        dat_wr(8'h04, 8'd0, 1'b0, 25'd0);
        cyc(8'h01, 1'b0, 1'b1, 25'h0929200);

        // Pointer write discards a latched byte 1.
        dat_wr(8'h77, 8'd0, 1'b0, 25'd0);
        ptr_wr(8'h10);
        dat_wr(8'h00, 8'd0, 1'b0, 25'd0);
        dat_wr(8'h00, 8'd0, 1'b0, 25'd0);
        cyc(8'h10, 1'b0, 1'b1, 25'h0000000);
        cyc(8'h0F, 1'b0, 1'b1, 25'h0FFFFFF);

        // Simultaneous strobes: pointer wins, data byte dropped.
        pal_ptr_wr   = 1'b1;
        pal_ptr_data = 8'h30;
        pal_data_wr  = 1'b1;
        pal_data     = 8'h70;
        cyc(8'd0, 1'b0, 1'b0, 25'd0);
        pal_ptr_wr  = 1'b0;
        pal_data_wr = 1'b0;
        dat_wr(8'h05, 8'd0, 1'b0, 25'd0);
        dat_wr(8'h06, 8'd0, 1'b0, 25'd0);
        cyc(8'h30, 1'b0, 1'b1, 25'h000DBB6);

        // Read/write collision on entry 5.
        ptr_wr(8'h05);
        dat_wr(8'h77, 8'h05, 1'b1, 25'h0496DFF);
        dat_wr(8'h07, 8'h05, 1'b1, 25'h0496DFF);
        cyc(8'h05, 1'b0, 1'b1, 25'h0FFFFFF);

        // Single blank cycle.
        cyc(8'd15, 1'b0, 1'b1, 25'h0FFFFFF);
        cyc(8'd15, 1'b1, 1'b1, 25'h1000000);
        cyc(8'd15, 1'b0, 1'b1, 25'h0FFFFFF);

        // Reset mid-frame: restarts the initialiser and clears the pointer.
        cyc(8'd15, 1'b0, 1'b0, 25'd0);
        cyc(8'd15, 1'b0, 1'b0, 25'd0);
        reset = 1'b1;
        cyc(8'd15, 1'b0, 1'b0, 25'd0);
        cyc(8'd15, 1'b0, 1'b0, 25'd0);
        chk("midreset_busy", {31'd0, init_busy}, 32'd1);
        chk("midreset_outputs", {7'd0, blank_out, video_red, video_green, video_blue}, 32'd0);
        reset = 1'b0;
        run_init();
        cyc(8'h05, 1'b0, 1'b1, 25'h0496DFF);
        cyc(8'h20, 1'b0, 1'b1, 25'h0000000);
        dat_wr(8'h11, 8'd0, 1'b0, 25'd0);
        dat_wr(8'h01, 8'd0, 1'b0, 25'd0);
        cyc(8'h00, 1'b0, 1'b1, 25'h0242424);
        cyc(8'h06, 1'b0, 1'b1, 25'h0B62424);

        repeat (3) cyc(8'd0, 1'b0, 1'b0, 25'd0);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vdp_super_palette_lookup.md
# vdp_super_palette_lookup

Converts the per-pixel 8-bit palette address produced by the super-resolution pixel fetch stages into 24-bit RGB for the video output encoder. It owns the 256-entry palette RAM, the CPU-side palette write path (pointer plus two-byte data sequence, V9958 register 16 / port 2 semantics), and a post-reset initialiser that loads the MSX2 default palette. It sits directly downstream of the super-res pixel stages and upstream of the HDMI/RGB serialiser.

## Interface
- No parameters. Depth is fixed at 256 entries of 9 bits (R3 G3 B3).
- reset  in  1  Asynchronous, active-high.
- clk  in  1  Pixel clock, shared with the pixel fetch stages.
- pal_ptr_wr  in  1  One-cycle strobe: load the palette pointer.
- pal_ptr_data  in  8  New pointer value.
- pal_data_wr  in  1  One-cycle strobe: palette data byte.
- pal_data  in  8  Byte 1 = {0,R[2:0],0,B[2:0]}; byte 2 = {5'b0,G[2:0]}.
- palette_addr  in  8  Pixel palette address, sampled every clk.
- blank  in  1  High when the pixel is outside the active display.
- init_busy  out  1  High while the default-palette initialiser runs.
- video_red / video_green / video_blue  out  8 each  Expanded RGB.
- blank_out  out  1  blank delayed to align with the RGB outputs.

## Operation
- Reset values: all outputs 0 except init_busy=1. Pointer=0, byte phase=first, init counter=0.
- Initialiser: after reset is released, write one entry per clk, index 0..255 (256 cycles). Entries 0..15 get MSX2 defaults as (R,G,B): 0:(0,0,0) 1:(0,0,0) 2:(1,6,1) 3:(3,7,3) 4:(1,1,7) 5:(2,3,7) 6:(5,1,1) 7:(2,6,7) 8:(7,1,1) 9:(7,3,3) 10:(6,6,1) 11:(6,6,4) 12:(1,4,1) 13:(6,2,5) 14:(5,5,5) 15:(7,7,7). Entries 16..255 get 0. init_busy drops the cycle after entry 255 is written.
- The CPU interface stalls on init_busy. The block ignores pal_ptr_wr and pal_data_wr while init_busy=1.
- Pointer write: set pointer = pal_ptr_data and force byte phase to first. Any latched byte 1 is discarded.
- Data write, phase first: latch R and B, then switch to phase second.
- Data write, phase second: commit {R,G,B} to entry[pointer], increment the pointer mod 256 (0xFF wraps to 0x00), and return to phase first.
- If pal_ptr_wr and pal_data_wr are asserted in the same cycle, the pointer write wins and the data write is dropped.
- Expansion per channel: 3-bit v becomes the 8-bit value {v, v, v[2:1]}. Examples: 0 -> 0x00, 1 -> 0x24, 7 -> 0xFF.
- Blanking: when the delayed blank is high, or init_busy was high when the pixel was sampled, RGB outputs are 0.
- Reset asserted mid-operation clears the pointer and byte phase and restarts the initialiser on release. Palette RAM contents are not cleared by reset itself; the initialiser overwrites them.

## Timing
- Pixel pipeline, two stages with a fixed 2-cycle latency:
  - Cycle N: palette_addr and blank are sampled.
  - Cycle N+1: the RAM read is registered.
  - Cycle N+2: video_* and blank_out reflect that pixel.
- The pipeline has no stall. A new address is accepted every clk, including during init; pixels sampled during init output black.
- Read/write collision: a commit to the entry being read in the same cycle returns the old value for that pixel. The new value is seen by addresses sampled from the next cycle on.
- A committed entry is readable by a palette_addr sampled on the clk after the byte-2 strobe.
- Maps to one simple dual-port BRAM with a registered read port.

## Test plan
- Reset release -> init_busy high for exactly 256 clks. Then palette_addr=15 gives RGB FF/FF/FF two clks later. palette_addr=2 gives 24/DB/24. palette_addr=200 gives 00/00/00.
- Pointer=0x20; data 0x52 then 0x03; then palette_addr=0x20 -> RGB B6/6D/49. Pointer is now 0x21.
- Pointer=0xFF; write two full entries (0x70,0x00) and (0x07,0x07) -> entry 0xFF = FF/00/00, entry 0x00 = 00/FF/FF, and the pointer wraps to 0x01.
- Write byte 1 (0x77), then a pointer write to 0x10, then byte 1 0x00 and byte 2 0x00 -> entry 0x10 = 00/00/00. Entry 0x0F is unchanged (FF/FF/FF).
- Hold palette_addr=0x05 while committing entry 5 = (7,7,7) -> the pixel sampled in the commit cycle outputs the old value 49/6D/FF, and the next pixel outputs FF/FF/FF.
- blank=1 on one cycle among constant palette_addr=15 -> exactly one output cycle of 00/00/00 with blank_out=1, aligned 2 clks later. Reset pulsed mid-frame -> init_busy reasserts and RGB outputs 0 until init completes.
